// File: rtl/cobs_encoder.sv
// ============================================================================
//  Module   : cobs_encoder
//  Purpose  : COBS framing encoder, byte-serial in/out with flag/busy handshake
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cobs_encoder (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_flag,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_busy,
  input  logic       busy,
  output logic       o_flag,
  output logic [7:0] o_data
);

  localparam logic [1:0] C_ST_COLLECT = 2'd0;
  localparam logic [1:0] C_ST_CODE    = 2'd1;
  localparam logic [1:0] C_ST_DATA    = 2'd2;
  localparam logic [1:0] C_ST_DELIM   = 2'd3;

  // A nonzero byte stored at this count fills the group to 254 (code 0xFF)
  localparam logic [7:0] C_LAST_SLOT  = 8'd253;

  logic [7:0] r_buf [0:253];
  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic [7:0] r_n;
  logic [7:0] r_rd;
  logic       r_zclose;
  logic       r_pend;
  logic       r_final;
  logic       r_oflag;
  logic [7:0] r_odata;

  logic       w_can_issue;
  logic       w_accept;
  logic       w_zero;
  logic       w_at_limit;
  logic       w_store;
  logic       w_close;
  logic       w_data_done;
  logic       w_issue;
  logic [7:0] w_issue_byte;

  // A byte may go out only when downstream is idle and the previous cycle was quiet
  assign w_can_issue = !busy && !r_oflag;
  assign w_accept    = (r_state == C_ST_COLLECT) && in_flag;
  assign w_zero      = (in_data == 8'h00);
  assign w_at_limit  = (r_n == C_LAST_SLOT);
  assign w_store     = w_accept && !w_zero;
  assign w_close     = w_accept && (w_zero || w_at_limit || in_last);
  assign w_data_done = (r_rd == r_n);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= C_ST_COLLECT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; DATA holds one extra cycle after its last byte so
  // in_busy drops only in the cycle after the final issue.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      C_ST_COLLECT: begin
        if (w_close) begin
          w_state_nxt = C_ST_CODE;
        end
      end
      C_ST_CODE: begin
        if (w_can_issue) begin
          w_state_nxt = C_ST_DATA;
        end
      end
      C_ST_DATA: begin
        if (w_data_done) begin
          if (!r_pend) begin
            w_state_nxt = C_ST_COLLECT;
          end else if (r_final || !r_zclose) begin
            w_state_nxt = C_ST_DELIM;
          end else begin
            w_state_nxt = C_ST_CODE;
          end
        end
      end
      C_ST_DELIM: begin
        if (r_rd[0]) begin
          w_state_nxt = C_ST_COLLECT;
        end
      end
      default: w_state_nxt = C_ST_COLLECT;
    endcase
  end

  // Output logic
  always_comb begin
    w_issue      = 1'b0;
    w_issue_byte = 8'h00;
    case (r_state)
      C_ST_CODE: begin
        w_issue      = w_can_issue;
        w_issue_byte = r_n + 8'd1;
      end
      C_ST_DATA: begin
        w_issue      = !w_data_done && w_can_issue;
        w_issue_byte = r_buf[r_rd];
      end
      C_ST_DELIM: begin
        w_issue      = !r_rd[0] && w_can_issue;
        w_issue_byte = 8'h00;
      end
      default: begin
        w_issue      = 1'b0;
        w_issue_byte = 8'h00;
      end
    endcase
  end

  assign in_busy = (r_state != C_ST_COLLECT);
  assign o_flag  = r_oflag;
  assign o_data  = r_odata;

  always_ff @(posedge clk) begin
    if (w_store) begin
      r_buf[r_n] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_n      <= 8'd0;
      r_rd     <= 8'd0;
      r_zclose <= 1'b1;
      r_pend   <= 1'b0;
      r_final  <= 1'b0;
      r_oflag  <= 1'b0;
      r_odata  <= 8'h00;
    end else begin
      r_oflag <= w_issue;
      if (w_issue) begin
        r_odata <= w_issue_byte;
      end
      case (r_state)
        C_ST_COLLECT: begin
          if (w_store) begin
            r_n <= r_n + 8'd1;
          end
          if (w_close) begin
            r_zclose <= w_zero;
            r_pend   <= in_last;
            // A nonzero last byte below the limit closes the packet's final group
            r_final  <= in_last && !w_zero && !w_at_limit;
          end
        end
        C_ST_CODE: begin
          if (w_can_issue) begin
            r_rd <= 8'd0;
          end
        end
        C_ST_DATA: begin
          if (!w_data_done) begin
            if (w_can_issue) begin
              r_rd <= r_rd + 8'd1;
            end
          end else begin
            r_n  <= 8'd0;
            r_rd <= 8'd0;
            if (r_pend && !r_final && r_zclose) begin
              r_final <= 1'b1;
            end
          end
        end
        C_ST_DELIM: begin
          if (w_issue) begin
            r_rd <= 8'd1;
          end else if (r_rd[0]) begin
            r_n      <= 8'd0;
            r_rd     <= 8'd0;
            r_zclose <= 1'b0;
            r_pend   <= 1'b0;
            r_final  <= 1'b0;
          end
        end
        default: begin
          r_rd <= 8'd0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cobs_encoder.sv
// ============================================================================
//  Module   : tb_cobs_encoder
//  Purpose  : scoreboard bench for cobs_encoder with directed packets
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_cobs_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_flag = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       in_busy;
  logic       busy = 1'b0;
  logic       o_flag;
  logic [7:0] o_data;

  cobs_encoder dut (
    .clk     (clk),
    .rst     (rst),
    .in_flag (in_flag),
    .in_data (in_data),
    .in_last (in_last),
    .in_busy (in_busy),
    .busy    (busy),
    .o_flag  (o_flag),
    .o_data  (o_data)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q [$];
  int         cyc = 0;
  int         last_flag_cyc = -100;
  int         rx_count = 0;
  int         out_cyc [0:1023];
  bit         busy_mode = 1'b0;
  int         busy_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor and downstream transmitter model
  always @(negedge clk) begin
    logic [7:0] e;
    if (o_flag) begin
      checks++;
      if (busy) begin
        errors++;
        $display("FAIL busy_violation: o_flag=1 while busy=1, required no issue");
      end
      checks++;
      if (cyc - last_flag_cyc < 2) begin
        errors++;
        $display("FAIL issue_gap: gap %0d cycles, required >= 2", cyc - last_flag_cyc);
      end
      last_flag_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_byte: got %02h, required no output", o_data);
      end else begin
        e = exp_q.pop_front();
        if (o_data !== e) begin
          errors++;
          $display("FAIL out_byte[%0d]: got %02h, required %02h", rx_count, o_data, e);
        end
      end
      if (rx_count < 1024) out_cyc[rx_count] = cyc;
      rx_count++;
      if (busy_mode) begin
        busy = 1'b1;
        busy_cnt = 37;
      end
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) busy = 1'b0;
    end
  end

  task automatic send(input logic [7:0] d, input logic l);
    int t = 0;
    while (in_busy === 1'b1 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 3000) begin
      errors++;
      $display("FAIL send_timeout: in_busy=%0b, required 0", in_busy);
    end
    in_flag = 1'b1;
    in_data = d;
    in_last = l;
    @(negedge clk);
    in_flag = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || in_busy === 1'b1) && t < 5000) begin
      @(negedge clk);
      #1;
      t++;
    end
    checks++;
    if (t >= 5000) begin
      errors++;
      $display("FAIL drain_timeout: %0d bytes outstanding, required 0", exp_q.size());
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic check_val(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  initial begin
    int base;
    int t;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("reset_o_flag", int'(o_flag), 0);
    check_val("reset_o_data", int'(o_data), 0);
    check_val("reset_in_busy", int'(in_busy), 0);

    // Mixed packet with an embedded zero
    base = rx_count;
    exp_q.push_back(8'h03); exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    exp_q.push_back(8'h02); exp_q.push_back(8'h33); exp_q.push_back(8'h00);
    send(8'h11, 1'b0);
    check_val("busy_after_plain_byte", int'(in_busy), 0);
    send(8'h22, 1'b0);
    send(8'h00, 1'b0);
    check_val("busy_after_zero", int'(in_busy), 1);
    send(8'h33, 1'b1);
    drain();
    check_val("t1_count", rx_count - base, 6);
    check_val("t1_gap_code_d0", out_cyc[base+1] - out_cyc[base], 2);
    check_val("t1_gap_d0_d1", out_cyc[base+2] - out_cyc[base+1], 2);
    check_val("t1_gap_code2_d", out_cyc[base+4] - out_cyc[base+3], 2);
    check_val("t1_gap_d_delim", out_cyc[base+5] - out_cyc[base+4], 2);

    // Lone zero byte
    base = rx_count;
    exp_q.push_back(8'h01); exp_q.push_back(8'h01); exp_q.push_back(8'h00);
    send(8'h00, 1'b1);
    drain();
    check_val("t2_count", rx_count - base, 3);

    // Exactly one full group, ends on the limit
    base = rx_count;
    exp_q.push_back(8'hFF);
    for (int i = 1; i <= 254; i++) exp_q.push_back(8'(i));
    exp_q.push_back(8'h00);
    for (int i = 1; i <= 254; i++) send(8'(i), (i == 254));
    drain();
    check_val("t3_count", rx_count - base, 256);

    // Full group followed by a one-byte final group
    base = rx_count;
    exp_q.push_back(8'hFF);
    for (int i = 1; i <= 254; i++) exp_q.push_back(8'(i));
    exp_q.push_back(8'h02); exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
    for (int i = 1; i <= 255; i++) send(8'(i), (i == 255));
    drain();
    check_val("t4_count", rx_count - base, 258);

    // Slow downstream, plus a byte offered while in_busy is high
    busy_mode = 1'b1;
    base = rx_count;
    exp_q.push_back(8'h04); exp_q.push_back(8'h05); exp_q.push_back(8'h06);
    exp_q.push_back(8'h07); exp_q.push_back(8'h00);
    send(8'h05, 1'b0);
    send(8'h06, 1'b0);
    send(8'h07, 1'b1);
    check_val("busy_before_drop", int'(in_busy), 1);
    in_flag = 1'b1;
    in_data = 8'h99;
    @(negedge clk);
    in_flag = 1'b0;
    drain();
    check_val("t5_count", rx_count - base, 5);
    busy_mode = 1'b0;
    t = 0;
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    base = rx_count;
    exp_q.push_back(8'h02); exp_q.push_back(8'hAB); exp_q.push_back(8'h00);
    send(8'hAB, 1'b1);
    drain();
    check_val("t5b_count", rx_count - base, 3);

    // Reset in the middle of a flush
    base = rx_count;
    exp_q.push_back(8'h0B); exp_q.push_back(8'h01); exp_q.push_back(8'h02);
    for (int i = 1; i <= 10; i++) send(8'(i), (i == 10));
    t = 0;
    while (rx_count < base + 3 && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    check_val("t6_pre_reset_count", rx_count - base, 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("t6_o_flag_after_rst", int'(o_flag), 0);
    check_val("t6_in_busy_after_rst", int'(in_busy), 0);
    repeat (40) @(negedge clk);
    check_val("t6_no_more_output", rx_count - base, 3);
    base = rx_count;
    exp_q.push_back(8'h02); exp_q.push_back(8'hAA); exp_q.push_back(8'h00);
    send(8'hAA, 1'b1);
    drain();
    check_val("t6_after_count", rx_count - base, 3);
    check_val("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
